// File: rtl/if_sched.sv
// rtl/if_sched.sv - two-requester round-robin scheduler for the compare-select datapath
module if_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [7:0]       in0_a,
    input  logic [15:0]      in0_b,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [7:0]       in1_a,
    input  logic [15:0]      in1_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_src,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {IDLE, EVAL, DIV, OUT} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               src_q, src_d;
    logic [7:0]         a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic [7:0]         rem_q, rem_d;
    logic [7:0]         quo_q, quo_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         res_q, res_d;
    logic [CNT_W-1:0]   done_q, done_d;

    logic               gnt1;
    logic               a_gt, b_gt;
    logic [15:0]        a_zx, diff16, prod16;
    logic [7:0]         s1, s2;
    logic [8:0]         trial;
    logic               ge;
    logic [7:0]         quo_n;

    // Ties go to the requester not served last; a lone requester always wins.
    assign gnt1      = in1_valid && (!in0_valid || !last_q);
    assign in0_ready = rst_n && (state_q == IDLE) && in0_valid && !gnt1;
    assign in1_ready = rst_n && (state_q == IDLE) && gnt1;

    assign a_zx   = {8'h00, a_q};
    assign a_gt   = a_zx > b_q;
    assign b_gt   = b_q > a_zx;
    assign diff16 = {8'h00, b_q[7:0]} - b_q;
    assign prod16 = {8'h00, b_q[7:0]} * b_q;
    assign s1     = a_gt ? (b_q[7:0] + a_q) : (b_gt ? diff16[7:0] : prod16[7:0]);
    assign s2     = a_gt ? (s1 - a_q) : (s1 + a_q);

    // One restoring step; a zero divisor yields all-ones quotient bits.
    assign trial = {rem_q, quo_q[7]};
    assign ge    = trial >= {1'b0, a_q};
    assign quo_n = {quo_q[6:0], ge};

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        src_d   = src_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (in0_valid || in1_valid) begin
                    a_d     = gnt1 ? in1_a : in0_a;
                    b_d     = gnt1 ? in1_b : in0_b;
                    src_d   = gnt1;
                    last_d  = gnt1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (a_gt || b_gt) begin
                    res_d   = s2;
                    state_d = OUT;
                end else begin
                    quo_d   = s1;
                    rem_d   = 8'h00;
                    cnt_d   = 4'd8;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = ge ? 8'(trial - {1'b0, a_q}) : trial[7:0];
                quo_d = quo_n;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d   = quo_n + 8'd1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    done_d  = done_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            src_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            src_q   <= src_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = (state_q == OUT);
    assign out_data  = {8'h00, res_q};
    assign out_src   = src_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = done_q;

endmodule
